axi4_mem_ctrl: RTL
==================

AXI4_MEM_CTRL -- requirements
Module: axi4_mem_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 32: AXI data and memory word width.
REQ-002 Parameter ADDR_WIDTH, default 12: AXI byte-address width.
REQ-003 Parameter MEM_ADDR_WIDTH, default 10: memory word-address width; memory depth is 2^MEM_ADDR_WIDTH.
REQ-004 ACLK  input  1  single clock; all state updates on its rising edge.
REQ-005 ARESET  input  1  reset, asynchronous, active-high.
REQ-006 AWVALID/AWREADY  input/output  1/1  write-address handshake.
REQ-007 AWADDR  input  ADDR_WIDTH  write burst start byte address.
REQ-008 AWLEN  input  8  write burst length minus one, INCR only.
REQ-009 WVALID/WREADY  input/output  1/1  write-data handshake.
REQ-010 WDATA  input  DATA_WIDTH  write beat data.
REQ-011 WLAST  input  1  master's last-beat marker.
REQ-012 BVALID/BREADY  output/input  1/1  write-response handshake.
REQ-013 BRESP  output  2  write response: 2'b00 OKAY, 2'b10 SLVERR.
REQ-014 ARVALID/ARREADY  input/output  1/1  read-address handshake.
REQ-015 ARADDR  input  ADDR_WIDTH  read burst start byte address.
REQ-016 ARLEN  input  8  read burst length minus one, INCR only.
REQ-017 RVALID/RREADY  output/input  1/1  read-data handshake.
REQ-018 RDATA  output  DATA_WIDTH  read beat data.
REQ-019 RRESP  output  2  always 2'b00.
REQ-020 RLAST  output  1  high with the final read beat.
REQ-021 mem_en, mem_we  output  1, 1  memory access strobe and write select.
REQ-022 mem_addr  output  MEM_ADDR_WIDTH  memory word address.
REQ-023 mem_wdata  output  DATA_WIDTH  memory write data.
REQ-024 mem_rdata  input  DATA_WIDTH  memory read data, valid one cycle after a read strobe.

Function
REQ-025 FSM states: IDLE, WR_DATA, WR_RESP, RD_ISSUE, RD_WAIT, RD_DATA; only one burst is in service at a time.
REQ-026 IDLE arbitration: one requester valid -> it is granted; both valid -> round-robin, granting the channel not served last; after reset, write wins.
REQ-027 AWREADY/ARREADY are high only in IDLE for the granted channel, at most one at a time; address handshake -> WR_DATA or RD_ISSUE next cycle.
REQ-028 On acceptance: word address = byte address[MEM_ADDR_WIDTH+1:2]; beat counter = 0; length = AXLEN latched.
REQ-029 Word address increments by 1 per beat, modulo 2^MEM_ADDR_WIDTH (wrap from 1023 to 0, no error).
REQ-030 WR_DATA: WREADY=1; in a cycle with WVALID, mem_en=mem_we=1, mem_addr=current word address, mem_wdata=WDATA (combinational, same cycle).
REQ-031 Write burst ends after exactly AWLEN+1 beats regardless of WLAST -> WR_RESP.
REQ-032 Any WLAST=1 before the final beat, or WLAST=0 on the final beat, sets BRESP=SLVERR for that burst; all beats are still written.
REQ-033 WR_RESP: BVALID=1, BRESP held stable until BREADY; BVALID&BREADY -> IDLE, BVALID low next cycle.
REQ-034 RD_ISSUE: mem_en=1, mem_we=0, mem_addr=current word address for one cycle -> RD_WAIT.
REQ-035 RD_WAIT: RDATA register <= mem_rdata -> RD_DATA.
REQ-036 RD_DATA: RVALID=1, RDATA and RLAST stable until RREADY; RLAST=1 only when beat counter = ARLEN.
REQ-037 RVALID&RREADY: if not last, go to RD_ISSUE with incremented address; else go to IDLE.
REQ-038 Read latency: ARVALID&ARREADY at cycle N -> first RVALID at N+3; with RREADY held high, one beat per 3 cycles.
REQ-039 mem_en=0 in every cycle and state not listed in REQ-030/REQ-034.
REQ-040 New requests arriving during a burst wait, unacknowledged, until IDLE.

Reset
REQ-041 ARESET asserted, even mid-burst, immediately forces: state IDLE; all READY/VALID outputs 0; mem_en=mem_we=0; RDATA, BRESP, RLAST = 0; round-robin pointer set so write has priority.
REQ-042 The in-flight burst is discarded and no response is issued for it after reset deasserts.

Verification
REQ-043 AW addr 0x010, len 3, data A0..A3, WLAST on beat 4 -> mem words 4..7 = A0..A3, BRESP=00.
REQ-044 AR addr 0x010, len 3, RREADY=1 -> RDATA A0..A3, RLAST on the 4th beat only, first RVALID 3 cycles after the handshake.
REQ-045 AWVALID and ARVALID rise in the same cycle twice in a row -> grants are write, read, write, read.
REQ-046 AW addr 0xFFC, len 1 -> beats written to word 1023 then word 0.
REQ-047 Write len 2 with WLAST on beat 2 -> 3 beats written, BRESP=10.
REQ-048 ARESET asserted during RD_DATA with RREADY=0 -> RVALID=0 immediately; the next AR is accepted from IDLE.

Source files
------------

// File: rtl/axi4_mem_ctrl_if.sv
// AXI4 subset bundle (AW/W/B/AR/R channels) between a master and axi4_mem_ctrl.
//
// Handshake rule for every channel: a transfer happens on the rising clock
// edge where VALID and READY are both high; the source holds VALID and its
// payload stable until that edge, and READY may depend on VALID.
interface axi4_mem_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12
) ();
    logic                  AWVALID;
    logic                  AWREADY;
    logic [ADDR_WIDTH-1:0] AWADDR;
    logic [7:0]            AWLEN;
    logic                  WVALID;
    logic                  WREADY;
    logic [DATA_WIDTH-1:0] WDATA;
    logic                  WLAST;
    logic                  BVALID;
    logic                  BREADY;
    logic [1:0]            BRESP;
    logic                  ARVALID;
    logic                  ARREADY;
    logic [ADDR_WIDTH-1:0] ARADDR;
    logic [7:0]            ARLEN;
    logic                  RVALID;
    logic                  RREADY;
    logic [DATA_WIDTH-1:0] RDATA;
    logic [1:0]            RRESP;
    logic                  RLAST;

    modport slave (
        input  AWVALID, AWADDR, AWLEN, WVALID, WDATA, WLAST, BREADY,
               ARVALID, ARADDR, ARLEN, RREADY,
        output AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP, RLAST
    );

    modport master (
        output AWVALID, AWADDR, AWLEN, WVALID, WDATA, WLAST, BREADY,
               ARVALID, ARADDR, ARLEN, RREADY,
        input  AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP, RLAST
    );
endinterface

// File: rtl/axi4_mem_ctrl.sv
// AXI4 INCR-burst slave in front of a single-port synchronous memory.
// One burst in service at a time; writes and reads share the memory port and
// are arbitrated round-robin in IDLE.
module axi4_mem_ctrl #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 12,
    parameter int MEM_ADDR_WIDTH = 10
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    axi4_mem_ctrl_if.slave            axi,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    input  logic [DATA_WIDTH-1:0]     mem_rdata,
    output logic [2:0]                dbg_state
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_DATA  = 3'd1,
        WR_RESP  = 3'd2,
        RD_ISSUE = 3'd3,
        RD_WAIT  = 3'd4,
        RD_DATA  = 3'd5
    } state_t;

    state_t                    state_q, state_d;
    logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]                cnt_q, cnt_d;
    logic [7:0]                len_q, len_d;
    logic                      err_q, err_d;
    logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
    // High when the most recent grant went to the write channel, so a
    // simultaneous request next time goes to the read channel.
    logic                      last_wr_q, last_wr_d;

    logic                      grant_wr, grant_rd, beat_last;
    logic [ADDR_WIDTH-1:0]     awaddr_w, araddr_w;
    logic                      unused_addr_bits;

    assign awaddr_w         = axi.AWADDR;
    assign araddr_w         = axi.ARADDR;
    // Byte-lane bits and any address bits above the memory range are ignored.
    assign unused_addr_bits = ^{awaddr_w, araddr_w};
    assign dbg_state        = state_q;

    // State and datapath registers; reset abandons any burst in flight.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            cnt_q     <= '0;
            len_q     <= '0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            last_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            last_wr_q <= last_wr_d;
        end
    end

    // Next-state, arbitration, bus outputs and memory strobes.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        err_d     = err_q;
        rdata_d   = rdata_q;
        last_wr_d = last_wr_q;

        axi.AWREADY = 1'b0;
        axi.WREADY  = 1'b0;
        axi.BVALID  = 1'b0;
        axi.BRESP   = 2'b00;
        axi.ARREADY = 1'b0;
        axi.RVALID  = 1'b0;
        axi.RDATA   = rdata_q;
        axi.RRESP   = 2'b00;
        axi.RLAST   = 1'b0;

        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = addr_q;
        mem_wdata = axi.WDATA;

        grant_wr  = axi.AWVALID && (!axi.ARVALID || !last_wr_q);
        grant_rd  = axi.ARVALID && !grant_wr;
        beat_last = (cnt_q == len_q);

        case (state_q)
            IDLE: begin
                axi.AWREADY = grant_wr;
                axi.ARREADY = grant_rd;
                if (grant_wr) begin
                    state_d   = WR_DATA;
                    addr_d    = awaddr_w[MEM_ADDR_WIDTH+1:2];
                    cnt_d     = 8'd0;
                    len_d     = axi.AWLEN;
                    err_d     = 1'b0;
                    last_wr_d = 1'b1;
                end else if (grant_rd) begin
                    state_d   = RD_ISSUE;
                    addr_d    = araddr_w[MEM_ADDR_WIDTH+1:2];
                    cnt_d     = 8'd0;
                    len_d     = axi.ARLEN;
                    last_wr_d = 1'b0;
                end
            end
            WR_DATA: begin
                axi.WREADY = 1'b1;
                if (axi.WVALID) begin
                    mem_en = 1'b1;
                    mem_we = 1'b1;
                    // WLAST only flags a protocol error; the beat count decides.
                    if (axi.WLAST != beat_last) begin
                        err_d = 1'b1;
                    end
                    if (beat_last) begin
                        state_d = WR_RESP;
                    end else begin
                        cnt_d  = cnt_q + 8'd1;
                        addr_d = addr_q + MEM_ADDR_WIDTH'(1);
                    end
                end
            end
            WR_RESP: begin
                axi.BVALID = 1'b1;
                axi.BRESP  = err_q ? 2'b10 : 2'b00;
                if (axi.BREADY) begin
                    state_d = IDLE;
                end
            end
            RD_ISSUE: begin
                mem_en  = 1'b1;
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                rdata_d = mem_rdata;
                state_d = RD_DATA;
            end
            RD_DATA: begin
                axi.RVALID = 1'b1;
                axi.RLAST  = beat_last;
                if (axi.RREADY) begin
                    if (beat_last) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d   = cnt_q + 8'd1;
                        addr_d  = addr_q + MEM_ADDR_WIDTH'(1);
                        state_d = RD_ISSUE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
